// File: rtl/square_if.sv
// Strobe/acknowledge handshake bundle for the iterative squarer:
// operand in on input_a*, full-width result out on output_z*.
interface square_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0]   input_a;
  logic               input_a_stb;
  logic               input_a_ack;
  logic [2*WIDTH-1:0] output_z;
  logic               output_z_stb;
  logic               output_z_ack;

  modport master (
    output input_a,
    output input_a_stb,
    input  input_a_ack,
    input  output_z,
    input  output_z_stb,
    output output_z_ack
  );

  modport slave (
    input  input_a,
    input  input_a_stb,
    output input_a_ack,
    output output_z,
    output output_z_stb,
    input  output_z_ack
  );
endinterface

// File: rtl/square.sv
// Iterative unsigned squarer: z = a*a, one radix-2 shift-add step per clock,
// operand and result exchanged over strobe/acknowledge handshakes.
module square #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  square_if.slave  bus
);

  localparam int ZW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    GET_A    = 2'd0,
    MULTIPLY = 2'd1,
    PUT_Z    = 2'd2
  } state_t;

  // One shift-add step: add the multiplicand shifted by i when bit i is set.
  function automatic logic [ZW-1:0] shift_add_step(
    input logic [ZW-1:0]    acc,
    input logic [WIDTH-1:0] a,
    input logic [CW-1:0]    i
  );
    logic [ZW-1:0] partial;
    if (a[i]) begin
      partial = ZW'(a) << i;
    end else begin
      partial = '0;
    end
    return acc + partial;
  endfunction

  state_t          state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [ZW-1:0]   acc_q, acc_d;
  logic [ZW-1:0]   z_q, z_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ack_q, ack_d;
  logic            stb_q, stb_d;
  logic [ZW-1:0]   sum_s;

  assign sum_s = shift_add_step(acc_q, a_q, cnt_q);

  // Next-state and next-output computation for the handshake/iteration FSM.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    acc_d   = acc_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    ack_d   = ack_q;
    stb_d   = stb_q;
    case (state_q)
      GET_A: begin
        ack_d = 1'b1;
        if (bus.input_a_stb && ack_q) begin
          a_d     = bus.input_a;
          acc_d   = '0;
          cnt_d   = '0;
          ack_d   = 1'b0;
          state_d = MULTIPLY;
        end else begin
          state_d = GET_A;
        end
      end
      MULTIPLY: begin
        acc_d = sum_s;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          z_d     = sum_s;
          stb_d   = 1'b1;
          state_d = PUT_Z;
        end else begin
          state_d = MULTIPLY;
        end
      end
      PUT_Z: begin
        if (bus.output_z_ack) begin
          stb_d   = 1'b0;
          ack_d   = 1'b1;
          state_d = GET_A;
        end else begin
          state_d = PUT_Z;
        end
      end
      default: begin
        state_d = GET_A;
        ack_d   = 1'b0;
        stb_d   = 1'b0;
        cnt_d   = '0;
        acc_d   = '0;
      end
    endcase
  end

  // State and registered-output flops; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GET_A;
      a_q     <= '0;
      acc_q   <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      stb_q   <= stb_d;
    end
  end

  assign bus.input_a_ack  = ack_q;
  assign bus.output_z     = z_q;
  assign bus.output_z_stb = stb_q;

endmodule

// File: tb/tb_square.sv
// Self-checking bench for square: directed scenarios plus randomized traffic
// scored against a plain a*a model and an integer square-root loopback.
module tb_square;
  localparam int WIDTH = 32;
  localparam int N_RAND = 1000;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  square_if #(.WIDTH(WIDTH)) bus ();
  square #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint unsigned isqrt(input longint unsigned v);
    longint unsigned lo = 64'd0;
    longint unsigned hi = 64'h1_0000_0000;
    longint unsigned mid;
    while (hi - lo > 64'd1) begin
      mid = (lo + hi) / 64'd2;
      if (mid * mid <= v) lo = mid;
      else hi = mid;
    end
    return lo;
  endfunction

  task automatic send(input logic [31:0] a, output bit ok);
    ok = 1'b0;
    bus.input_a = a;
    bus.input_a_stb = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (bus.input_a_ack) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    bus.input_a_stb = 1'b0;
  endtask

  task automatic wait_result(output int lat, output logic [63:0] z, output bit ok);
    ok = 1'b0; lat = 0; z = '0;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (bus.output_z_stb) begin
        lat = k; z = bus.output_z; ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (bus.input_a_ack !== 1'b0 || bus.output_z_stb !== 1'b0 || bus.output_z !== 64'd0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d ack=%b stb=%b z=%0d required 0/0/0", k,
                 bus.input_a_ack, bus.output_z_stb, bus.output_z);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.input_a_ack !== 1'b1 || bus.output_z_stb !== 1'b0) begin
      failures++;
      $display("FAIL reset_release ack=%b stb=%b required ack=1 stb=0", bus.input_a_ack, bus.output_z_stb);
    end
  endtask

  task automatic test_basic();
    logic [31:0] vals [4];
    logic [63:0] z;
    int lat;
    bit ok;
    vals = '{32'd0, 32'd1, 32'd46341, 32'hFFFF_FFFF};
    bus.output_z_ack = 1'b1;
    foreach (vals[i]) begin
      send(vals[i], ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL basic_accept a=%0d not accepted", vals[i]); end
      wait_result(lat, z, ok);
      checks++;
      if (!ok || lat !== 32) begin
        failures++;
        $display("FAIL basic_latency a=%0d got=%0d required=32", vals[i], lat);
      end
      checks++;
      if (z !== 64'(vals[i]) * 64'(vals[i])) begin
        failures++;
        $display("FAIL basic_value a=%0d got=%0d required=%0d", vals[i], z, 64'(vals[i]) * 64'(vals[i]));
      end
    end
    checks++;
    if (z !== 64'hFFFF_FFFE_0000_0001) begin
      failures++;
      $display("FAIL max_value got=%h required=fffffffe00000001", z);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [63:0] z;
    int lat;
    bit ok;
    bus.output_z_ack = 1'b0;
    send(32'd12345, ok);
    wait_result(lat, z, ok);
    checks++;
    if (!ok || z !== 64'd152399025) begin
      failures++;
      $display("FAIL bp_value got=%0d required=152399025", z);
    end
    for (int k = 0; k < 10; k++) begin
      bus.input_a = $urandom;
      bus.input_a_stb = 1'b1;
      checks++;
      if (bus.output_z_stb !== 1'b1 || bus.output_z !== 64'd152399025 || bus.input_a_ack !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d stb=%b z=%0d in_ack=%b required 1/152399025/0", k,
                 bus.output_z_stb, bus.output_z, bus.input_a_ack);
      end
      tick();
    end
    bus.input_a_stb = 1'b0;
    bus.output_z_ack = 1'b1;
    tick();
    checks++;
    if (bus.output_z_stb !== 1'b0 || bus.input_a_ack !== 1'b1 || bus.output_z !== 64'd152399025) begin
      failures++;
      $display("FAIL bp_release stb=%b in_ack=%b z=%0d required 0/1/152399025",
               bus.output_z_stb, bus.input_a_ack, bus.output_z);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] z;
    int lat;
    bit ok;
    bit rose;
    bus.output_z_ack = 1'b1;
    send(32'd7, ok);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (bus.input_a_ack !== 1'b0 || bus.output_z_stb !== 1'b0 || bus.output_z !== 64'd0) begin
      failures++;
      $display("FAIL midrst_state ack=%b stb=%b z=%0d required 0/0/0",
               bus.input_a_ack, bus.output_z_stb, bus.output_z);
    end
    rst = 1'b0;
    rose = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.output_z_stb) rose = 1'b1;
    end
    checks++;
    if (rose !== 1'b0 || bus.input_a_ack !== 1'b1) begin
      failures++;
      $display("FAIL midrst_quiet stb_rose=%b ack=%b required 0/1", rose, bus.input_a_ack);
    end
    send(32'd9, ok);
    wait_result(lat, z, ok);
    checks++;
    if (!ok || lat !== 32 || z !== 64'd81) begin
      failures++;
      $display("FAIL midrst_next lat=%0d z=%0d required 32/81", lat, z);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int gap;
    bit seen;
    bus.output_z_ack = 1'b1;
    bus.input_a = 32'd3;
    bus.input_a_stb = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      tick();
      seen = bus.output_z_stb;
    end
    gap = 0;
    seen = 1'b0;
    for (int k = 1; k <= 100 && !seen; k++) begin
      tick();
      if (bus.output_z_stb) begin seen = 1'b1; gap = k; end
    end
    bus.input_a_stb = 1'b0;
    checks++;
    if (gap !== 34 || bus.output_z !== 64'd9) begin
      failures++;
      $display("FAIL b2b_period gap=%0d z=%0d required 34/9", gap, bus.output_z);
    end
    repeat (2) tick();
  endtask

  task automatic test_random();
    logic [31:0] exp_q[$];
    bit prod_to = 1'b0;
    fork
      begin : producer
        logic [31:0] a;
        int waited;
        for (int n = 0; n < N_RAND && !prod_to; n++) begin
          bus.input_a_stb = 1'b0;
          repeat ($urandom_range(0, 3)) begin
            bus.input_a = $urandom;
            tick();
          end
          a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 65535)) : 32'($urandom);
          bus.input_a = a;
          bus.input_a_stb = 1'b1;
          waited = 0;
          while (!bus.input_a_ack && waited < 200) begin tick(); waited++; end
          if (waited >= 200) prod_to = 1'b1;
          else begin
            tick();
            exp_q.push_back(a);
          end
        end
        bus.input_a_stb = 1'b0;
      end
      begin : consumer
        int got = 0;
        int budget = 0;
        logic ackv, s;
        logic [63:0] z;
        logic [31:0] a;
        while (got < N_RAND && budget < 80000 && !prod_to) begin
          ackv = ($urandom_range(0, 3) != 0);
          bus.output_z_ack = ackv;
          s = bus.output_z_stb;
          z = bus.output_z;
          tick();
          budget++;
          if (s && ackv) begin
            got++;
            checks++;
            if (exp_q.size() == 0) begin
              failures++;
              $display("FAIL rand_extra result=%0d with no operand outstanding", z);
            end else begin
              a = exp_q.pop_front();
              if (z !== 64'(a) * 64'(a)) begin
                failures++;
                $display("FAIL rand_value n=%0d a=%0d got=%0d required=%0d", got, a, z, 64'(a) * 64'(a));
              end
              if (a < 32'd65536) begin
                checks++;
                if (isqrt(z) !== longint'(a)) begin
                  failures++;
                  $display("FAIL rand_loopback a=%0d sqrt_of_result=%0d", a, isqrt(z));
                end
              end
            end
          end
        end
        checks++;
        if (got !== N_RAND) begin
          failures++;
          $display("FAIL rand_count got=%0d required=%0d", got, N_RAND);
        end
      end
    join
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL rand_leftover outstanding=%0d required=0", exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.input_a = '0;
    bus.input_a_stb = 1'b0;
    bus.output_z_ack = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
